// File: rtl/id_pkg.sv
// Shared decode constants for the instruction-decode pipeline stage:
// instruction class encodings, out_ctrl bit positions and the condition check.
package id_pkg;

  localparam int unsigned CLASS_W = 4;
  localparam int unsigned COND_W  = 4;
  localparam int unsigned CTRL_W  = 5;

  localparam logic [CLASS_W-1:0] NOP    = 4'b0000;
  localparam logic [CLASS_W-1:0] MMU    = 4'b0010;
  localparam logic [CLASS_W-1:0] JUMP   = 4'b0100;
  localparam logic [CLASS_W-1:0] SETCTR = 4'b0111;
  localparam logic [CLASS_W-1:0] ALU    = 4'b1000;

  localparam int unsigned CTRL_ALU_WRITE   = 4;
  localparam int unsigned CTRL_MMU_WRITE   = 3;
  localparam int unsigned CTRL_MMU_EXECUTE = 2;
  localparam int unsigned CTRL_SET_CTR     = 1;
  localparam int unsigned CTRL_FINISHED    = 0;

  typedef struct packed {
    logic alu_write;
    logic mmu_write;
    logic mmu_execute;
    logic set_ctr;
    logic finished;
  } ctrl_t;

  // Condition nibble is a set of OR-ed enables: {zf=1, zf=0, cf=1, cf=0}.
  function automatic logic cond_ok(input logic [COND_W-1:0] cond,
                                   input logic cf, input logic zf);
    return (cond[3] & zf) | (cond[2] & ~zf) | (cond[1] & cf) | (cond[0] & ~cf);
  endfunction

endpackage

// File: rtl/id_decode.sv
// Purely combinational instruction decoder: control bits, registers read,
// and the next program counter.
module id_decode
  import id_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned INSN_LEN = 3
) (
  input  logic [3*DATA_W-1:0] instruction,
  input  logic                cf,
  input  logic                zf,
  input  logic [DATA_W-1:0]   register_bus_a,
  input  logic [DATA_W-1:0]   register_bus_b,
  input  logic [2*DATA_W-1:0] pc,
  output ctrl_t               ctrl_c,
  output logic [DATA_W-1:0]   field_a_c,
  output logic [DATA_W-1:0]   field_b_c,
  output logic [DATA_W-1:0]   regs_used_c,
  output logic [2*DATA_W-1:0] next_pc_c
);

  localparam int unsigned ADDR_W = 2 * DATA_W;

  logic [7:0]         opcode;
  logic [CLASS_W-1:0] cls;
  logic [COND_W-1:0]  cond;
  logic               exec;
  logic               is_alu;
  logic               is_mmu_exe;
  logic               is_jump;
  logic               is_set_ctr;
  logic               a_read;
  logic               b_read;

  assign opcode    = instruction[2*DATA_W +: 8];
  assign cls       = opcode[7:4];
  assign cond      = opcode[3:0];
  assign field_a_c = instruction[DATA_W +: DATA_W];
  assign field_b_c = instruction[0 +: DATA_W];

  always_comb begin
    ctrl_c      = '0;
    regs_used_c = '0;
    next_pc_c   = pc + ADDR_W'(INSN_LEN);

    exec       = cond_ok(cond, cf, zf);
    is_alu     = cls[3];
    is_mmu_exe = (cls[3:1] == MMU[3:1]);
    is_jump    = (cls[3:1] == JUMP[3:1]);
    is_set_ctr = (cls == SETCTR);

    // Operand usage drives the hazard check, independent of the condition.
    a_read = (is_alu && (cls[2:0] != 3'b100)) || (cls == JUMP) || is_mmu_exe;
    b_read = (is_alu && (cls[2:0] != 3'b011)) || (cls == JUMP) || (cls == (MMU | 4'b0001));
    if (a_read) regs_used_c = regs_used_c | field_a_c;
    if (b_read) regs_used_c = regs_used_c | field_b_c;

    ctrl_c.alu_write   = exec & is_alu;
    ctrl_c.mmu_write   = exec & cls[0];
    ctrl_c.mmu_execute = exec & is_mmu_exe;
    ctrl_c.set_ctr     = exec & is_set_ctr;
    ctrl_c.finished    = is_jump | is_set_ctr | ~exec | (cls == NOP);

    // Odd jump classes carry the target inline; even ones jump through registers.
    if (exec && is_jump) begin
      next_pc_c = cls[0] ? {field_b_c, field_a_c} : {register_bus_b, register_bus_a};
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode pipeline stage: PC, one-deep output register, handshake,
// flush redirect and optional interrupt entry (enabled by ID_STAGE_PIPE_IRQ_EN).
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned INSN_LEN     = 3,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int unsigned IRQ_VECTOR   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3*DATA_W-1:0] instruction,
  input  logic                cf,
  input  logic                zf,
  input  logic [DATA_W-1:0]   register_bus_a,
  input  logic [DATA_W-1:0]   register_bus_b,
  input  logic [DATA_W-1:0]   busy_mask,
  input  logic                flush,
  input  logic [2*DATA_W-1:0] flush_addr,
  input  logic                irq_req,
  output logic                irq_ack,
  output logic [2*DATA_W-1:0] fetch_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CTRL_W-1:0]   out_ctrl,
  output logic [DATA_W-1:0]   out_regmask_a,
  output logic [DATA_W-1:0]   out_regmask_b,
  output logic [DATA_W-1:0]   out_ctr_value,
  output logic [2*DATA_W-1:0] out_ret_addr
);

  localparam int unsigned ADDR_W = 2 * DATA_W;

  logic [ADDR_W-1:0] pc;
  logic              valid_q;
  ctrl_t             ctrl_q;
  logic [DATA_W-1:0] mask_a_q;
  logic [DATA_W-1:0] mask_b_q;
  logic [DATA_W-1:0] ctr_q;

  ctrl_t             dec_ctrl;
  logic [DATA_W-1:0] dec_field_a;
  logic [DATA_W-1:0] dec_field_b;
  logic [DATA_W-1:0] dec_regs_used;
  logic [ADDR_W-1:0] dec_next_pc;

  logic hazard_c;
  logic accept_c;
  logic take_irq_c;

  id_decode #(
    .DATA_W  (DATA_W),
    .INSN_LEN(INSN_LEN)
  ) u_decode (
    .instruction   (instruction),
    .cf            (cf),
    .zf            (zf),
    .register_bus_a(register_bus_a),
    .register_bus_b(register_bus_b),
    .pc            (pc),
    .ctrl_c        (dec_ctrl),
    .field_a_c     (dec_field_a),
    .field_b_c     (dec_field_b),
    .regs_used_c   (dec_regs_used),
    .next_pc_c     (dec_next_pc)
  );

  assign hazard_c = |(dec_regs_used & busy_mask);
  assign in_ready = ~hazard_c & (~valid_q | out_ready) & ~flush;
  assign accept_c = in_valid & in_ready;

  // PC and output bundle; flush beats accept, and the bundle only changes on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= ADDR_W'(RESET_VECTOR);
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      mask_a_q <= '0;
      mask_b_q <= '0;
      ctr_q    <= '0;
    end else if (flush) begin
      pc      <= flush_addr;
      valid_q <= 1'b0;
    end else if (accept_c) begin
      pc       <= take_irq_c ? ADDR_W'(IRQ_VECTOR) : dec_next_pc;
      valid_q  <= 1'b1;
      ctrl_q   <= dec_ctrl;
      mask_a_q <= dec_field_a;
      mask_b_q <= dec_field_b;
      ctr_q    <= dec_field_a;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef ID_STAGE_PIPE_IRQ_EN
  logic              irq_pending;
  logic              irq_ack_q;
  logic [ADDR_W-1:0] ret_addr_q;

  assign take_irq_c = accept_c & irq_pending;

  // Sticky request; a level still high on the taking cycle re-arms it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_pending <= 1'b0;
      irq_ack_q   <= 1'b0;
      ret_addr_q  <= '0;
    end else begin
      irq_ack_q <= take_irq_c;
      if (take_irq_c) begin
        irq_pending <= irq_req;
        ret_addr_q  <= dec_next_pc;
      end else begin
        irq_pending <= irq_pending | irq_req;
      end
    end
  end

  assign irq_ack      = irq_ack_q;
  assign out_ret_addr = ret_addr_q;
`else
  logic unused_irq;

  assign unused_irq   = irq_req;
  assign take_irq_c   = 1'b0;
  assign irq_ack      = 1'b0;
  assign out_ret_addr = '0;
`endif

  assign fetch_addr    = pc;
  assign out_valid     = valid_q;
  assign out_ctrl      = ctrl_q;
  assign out_regmask_a = mask_a_q;
  assign out_regmask_b = mask_b_q;
  assign out_ctr_value = ctr_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed instructions push expected
// bundles, a monitor pops them on every output handshake.
module tb_id_stage_pipe;

`ifdef ID_STAGE_PIPE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif
  localparam logic [15:0] IRQ_VEC = 16'h0080;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] instruction = '0;
  logic        cf = 1'b0;
  logic        zf = 1'b0;
  logic [7:0]  register_bus_a = '0;
  logic [7:0]  register_bus_b = '0;
  logic [7:0]  busy_mask = '0;
  logic        flush = 1'b0;
  logic [15:0] flush_addr = '0;
  logic        irq_req = 1'b0;
  logic        irq_ack;
  logic [15:0] fetch_addr;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_ctrl;
  logic [7:0]  out_regmask_a;
  logic [7:0]  out_regmask_b;
  logic [7:0]  out_ctr_value;
  logic [15:0] out_ret_addr;

  typedef struct packed {
    logic [4:0]  ctrl;
    logic [7:0]  ma;
    logic [7:0]  mb;
    logic [7:0]  ctr;
    logic [15:0] ret;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ack_cnt = 0;

  id_stage_pipe #(
    .DATA_W      (8),
    .INSN_LEN    (3),
    .RESET_VECTOR(0),
    .IRQ_VECTOR  (32'(IRQ_VEC))
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .instruction   (instruction),
    .cf            (cf),
    .zf            (zf),
    .register_bus_a(register_bus_a),
    .register_bus_b(register_bus_b),
    .busy_mask     (busy_mask),
    .flush         (flush),
    .flush_addr    (flush_addr),
    .irq_req       (irq_req),
    .irq_ack       (irq_ack),
    .fetch_addr    (fetch_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ctrl      (out_ctrl),
    .out_regmask_a (out_regmask_a),
    .out_regmask_b (out_regmask_b),
    .out_ctr_value (out_ctr_value),
    .out_ret_addr  (out_ret_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one instruction, wait for acceptance, queue its bundle, check the new PC.
  task automatic issue(input logic [23:0] insn, input logic c, input logic z,
                       input logic [4:0] ectrl, input logic [15:0] epc,
                       input logic [15:0] eret);
    int   n;
    exp_t e;
    in_valid    = 1'b1;
    instruction = insn;
    cf          = c;
    zf          = z;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: insn 0x%06h never accepted", insn);
      in_valid = 1'b0;
      return;
    end
    e.ctrl = ectrl;
    e.ma   = insn[15:8];
    e.mb   = insn[7:0];
    e.ctr  = insn[15:8];
    e.ret  = eret;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pc_after_accept", 32'(fetch_addr), 32'(epc));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_bundle: ctrl 0x%0h with empty scoreboard", out_ctrl);
      end else begin
        e = q.pop_front();
        chk("bundle_ctrl", 32'(out_ctrl), 32'(e.ctrl));
        chk("bundle_mask_a", 32'(out_regmask_a), 32'(e.ma));
        chk("bundle_mask_b", 32'(out_regmask_b), 32'(e.mb));
        chk("bundle_ctr", 32'(out_ctr_value), 32'(e.ctr));
        chk("bundle_ret", 32'(out_ret_addr), 32'(e.ret));
      end
    end
  end

  always @(negedge clk) if (irq_ack) ack_cnt++;

  initial begin
    logic [15:0] p;
    logic [15:0] r;
    int          n;

    // Reset state
    step(2);
    chk("rst_pc", 32'(fetch_addr), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_ctrl", 32'(out_ctrl), 32'h0);
    chk("rst_irq_ack", 32'(irq_ack), 32'h0);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    step(1);
    rst_n = 1'b1;

    issue(24'h000000, 1'b0, 1'b0, 5'b00001, 16'h0003, 16'h0);
    issue(24'h5F3412, 1'b0, 1'b0, 5'b01001, 16'h1234, 16'h0);
    issue(24'h580000, 1'b0, 1'b0, 5'b00001, 16'h1237, 16'h0);
    register_bus_a = 8'h10;
    register_bus_b = 8'h00;
    issue(24'h4F0000, 1'b0, 1'b1, 5'b00001, 16'h0010, 16'h0);

    // Interrupt request arrives together with a flush: flush wins
    irq_req     = 1'b1;
    flush       = 1'b1;
    flush_addr  = 16'h0200;
    in_valid    = 1'b1;
    instruction = 24'h8F0401;
    @(negedge clk);
    chk("flush_blocks_ready", 32'(in_ready), 32'h0);
    step(1);
    irq_req  = 1'b0;
    in_valid = 1'b0;
    chk("flush_pc", 32'(fetch_addr), 32'h0200);
    chk("flush_no_ack", 32'(irq_ack), 32'h0);
    flush_addr = 16'h0010;
    step(1);
    flush = 1'b0;
    chk("flush_back_pc", 32'(fetch_addr), 32'h0010);

    // Register hazard stalls the ALU op until busy_mask clears
    busy_mask   = 8'h04;
    in_valid    = 1'b1;
    instruction = 24'h8F0401;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hazard_in_ready", 32'(in_ready), 32'h0);
      chk("hazard_pc_hold", 32'(fetch_addr), 32'h0010);
    end
    step(1);
    busy_mask = 8'h00;
    p = IRQ_ON ? IRQ_VEC : 16'h0013;
    r = IRQ_ON ? 16'h0013 : 16'h0000;
    issue(24'h8F0401, 1'b0, 1'b0, 5'b10000, p, r);
    chk("irq_ack_pulse", 32'(irq_ack), 32'(IRQ_ON));
    step(1);
    chk("irq_ack_single", 32'(irq_ack), 32'h0);

    // Downstream stall holds the bundle
    out_ready = 1'b0;
    issue(24'h7F2200, 1'b0, 1'b0, 5'b01011, p + 16'd3, r);
    in_valid    = 1'b1;
    instruction = 24'h000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'h1);
      chk("stall_in_ready", 32'(in_ready), 32'h0);
      chk("stall_pc", 32'(fetch_addr), 32'(p + 16'd3));
      chk("stall_ctrl", 32'(out_ctrl), 32'h0B);
      chk("stall_ctr", 32'(out_ctr_value), 32'h22);
    end
    step(1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(1);

    issue(24'h210700, 1'b0, 1'b0, 5'b00100, p + 16'd6, r);
    issue(24'h220700, 1'b0, 1'b0, 5'b00001, p + 16'd9, r);
    step(2);

    // Address wrap
    flush      = 1'b1;
    flush_addr = 16'hFFFE;
    step(1);
    flush = 1'b0;
    chk("wrap_flush_pc", 32'(fetch_addr), 32'hFFFE);
    issue(24'h000000, 1'b1, 1'b1, 5'b00001, 16'h0001, r);
    step(2);

    // Reset while a bundle is stalled discards it
    out_ready = 1'b0;
    issue(24'h8F0102, 1'b0, 1'b0, 5'b10000, 16'h0004, r);
    chk("pre_reset_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    step(1);
    if (q.size() > 0) q.delete(q.size() - 1);
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_pc", 32'(fetch_addr), 32'h0);
    chk("midrst_ctrl", 32'(out_ctrl), 32'h0);
    chk("midrst_mask_a", 32'(out_regmask_a), 32'h0);
    chk("midrst_ret", 32'(out_ret_addr), 32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step(1);
    issue(24'h000000, 1'b0, 1'b0, 5'b00001, 16'h0003, 16'h0);

    n = 0;
    while (q.size() != 0 && n < 20) begin
      step(1);
      n++;
    end
    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    chk("irq_ack_count", 32'(ack_cnt), 32'(IRQ_ON));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning register/field width; instruction width is 3*DATA_W and address width is 2*DATA_W.
REQ-002 SHALL have parameter INSN_LEN, default 3, meaning the sequential address increment.
REQ-003 SHALL have parameter RESET_VECTOR, default 0, meaning the PC value after reset.
REQ-004 SHALL have parameter IRQ_VECTOR, default 0, meaning the interrupt entry address.
REQ-005 Ports, one per line, name direction width meaning; one clock; reset is synchronous and active-low:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  instruction word present
in_ready  output  1  stage can accept
instruction  input  3*DATA_W  opcode [3D-1:2D], field A [2D-1:D], field B [D-1:0]
cf, zf  input  1 each  flags sampled at accept
register_bus_a, register_bus_b  input  DATA_W each  operand values for register jumps
busy_mask  input  DATA_W  registers with writes in flight downstream
flush  input  1  discard output and redirect
flush_addr  input  2*DATA_W  redirect target
irq_req  input  1  level interrupt request
irq_ack  output  1  one-cycle pulse when an interrupt is taken
fetch_addr  output  2*DATA_W  current PC
out_valid  output  1  decoded bundle valid
out_ready  input  1  downstream accepts bundle
out_ctrl  output  5  {alu_write, mmu_write, mmu_execute, set_ctr, finished}
out_regmask_a, out_regmask_b  output  DATA_W each  fields A and B
out_ctr_value  output  DATA_W  field A
out_ret_addr  output  2*DATA_W  interrupt return address

Function
REQ-006 Decode: opcode bits[7:4] are the class, and opcode bits[3:0] are the {zf=1, zf=0, cf=1, cf=0} enable conditions; exec = cond_ok.
REQ-007 Decode classes: alu = class[3]; mmu_execute = class[3:1]==001; jump = class[3:1]==010; set_ctr = class==0111; mmu_write = class[0].
REQ-008 registers_used: A read = alu and class[2:0]!=100, or class==0100, or class[3:1]==001; B read = alu and class[2:0]!=011, or class==0100, or class==0011; registers_used = (A read ? field A : 0) | (B read ? field B : 0).
REQ-009 hazard = |(registers_used & busy_mask); in_ready = !hazard & (!out_valid | out_ready) & !flush.
REQ-010 Accept occurs on a cycle with in_valid & in_ready; at the next edge the output register loads, out_valid=1, so latency is 1 cycle.
REQ-011 Control outputs are gated by exec; finished = jump | set_ctr | !exec | class==0000.
REQ-012 next = exec&jump ? (class[0] ? {B,A} : {bus_b,bus_a}) : pc+INSN_LEN; the addition wraps modulo 2^(2*DATA_W).
REQ-013 On accept, pc <= next.
REQ-014 out_valid clears when out_ready & !accept; the bundle SHALL be held stable while out_valid & !out_ready.
REQ-015 flush: at the next edge, pc <= flush_addr and out_valid <= 0; flush has priority over accept and interrupt.
REQ-016 irq_req sets irq_pending (sticky).
REQ-017 At the first accept with irq_pending: out_ret_addr <= next, pc <= IRQ_VECTOR, irq_ack pulses, and pending clears unless irq_req is still high on that cycle.
REQ-018 If no interrupt is taken, out_ret_addr holds its value.

Reset
REQ-019 While rst_n=0 at an edge: pc=RESET_VECTOR, out_valid=0, out_ctrl=0, masks/ctr/ret_addr=0, irq_pending=0, irq_ack=0.
REQ-020 Reset mid-stall SHALL discard the held bundle.

Configuration
REQ-021 Macro ID_STAGE_PIPE_IRQ_EN defined: REQ-016..018 are active.
REQ-022 Macro ID_STAGE_PIPE_IRQ_EN absent: no pending flop, irq_ack=0, out_ret_addr=0, and irq_req is ignored.

Structure
REQ-023 A shared package id_pkg SHALL hold the class constants (ALU, MMU, JUMP, SETCTR, NOP) and the out_ctrl bit indices.
REQ-024 One sub-module id_decode (purely combinational: REQ-006..008, 011, 012) SHALL be instantiated; id_stage_pipe holds pc, output register, handshake and interrupt state.

Verification
REQ-025 Reset then in_valid with instruction 0x000000 -> fetch_addr 0 then 3, out_valid=1 next cycle, finished=1.
REQ-026 Immediate jump 0x5F3412 (class 0101, cond 1111) -> pc=0x1234; with cond 0x8 and zf=0 -> pc=old+3 and finished=1.
REQ-027 ALU op with field A=0x04, busy_mask=0x04 -> in_ready=0; on clearing busy_mask -> accept next cycle.
REQ-028 out_ready=0 for 3 cycles with a bundle valid -> outputs stable, in_ready=0, no pc change.
REQ-029 irq_req pulse, then accept at pc=0x0010 (non-jump) -> out_ret_addr=0x0013, pc=IRQ_VECTOR, single irq_ack; simultaneous flush to 0x0200 -> pc=0x0200, irq stays pending.
REQ-030 pc=0xFFFE non-jump accept -> pc=0x0001 (wrap).
